alu_v: RTL and testbench
========================

// Module: alu_v
// PURPOSE
//  Lane-parallel vector ALU for the vector CPU execute stage.
//  Applies one selector-chosen operation independently to every lane of two packed vector operands.
//  Result is registered. No carries, flags or saturation cross between lanes.
// PARAMETERS
//  DATA_WIDTH     8   bits per lane element
//  LANES          8   number of lanes
//  SELECTOR_SIZE  4   opcode width
// PORTS
//  clk       in   1                      single clock; all state updates on its rising edge
//  rst       in   1                      synchronous, active-high reset
//  selector  in   SELECTOR_SIZE          operation select
//  operand1  in   [LANES-1:0][DATA_WIDTH-1:0]  vector A; lane i = operand1[i]
//  operand2  in   [LANES-1:0][DATA_WIDTH-1:0]  vector B; lane i = operand2[i]
//  out       out  [LANES-1:0][DATA_WIDTH-1:0]  registered result; lane i = op(A[i],B[i])
// BEHAVIOUR
//  - Reset and latency
//    - rst=1 at a clk edge clears out to all zeros.
//    - Otherwise out <= f(selector, operand1, operand2) every edge: 1-cycle latency, no handshake.
//    - A new operation can be issued every cycle.
//  - Opcodes. All results are the low DATA_WIDTH bits, unsigned modular (wrap-around):
//    - 4'b0000 AND   A & B
//    - 4'b0001 OR    A | B
//    - 4'b0010 XOR   A ^ B
//    - 4'b0011 NOT   ~A (B ignored)
//    - 4'b0100 ADD   A + B; carry discarded (0xFF+0x0F=0x0E)
//    - 4'b0101 MUL   A * B; low DATA_WIDTH bits of the product (0x0E*0x02=0x1C)
//    - 4'b0110 SLL   A << B[$clog2(DATA_WIDTH)-1:0]
//    - 4'b0111 SRL   A >> B[$clog2(DATA_WIDTH)-1:0], logical
//    - 4'b1000 SRA   A >>> B[$clog2(DATA_WIDTH)-1:0], sign-filling
//    - 4'b1001 MIN   unsigned minimum
//    - 4'b1010 MAX   unsigned maximum
//    - 4'b1011 PASSA A
//    - 4'b1100 PASSB B
//    - 4'b1101 SUB   A - B, two's-complement wrap (0x05-0x08=0xFD)
//    - 4'b1110 EQ    lane = all-ones if A==B, else 0
//    - 4'b1111 reserved: lane result 0
//  - Shift amounts use only the low log2 bits of the lane's B. Shift by 0 returns A.
//  - Lanes are fully independent. The same opcode applies to all lanes.
//  - Selector changes take effect at the next edge. There is no mid-operation state.
//  - rst asserted together with valid operands: reset wins, out=0.
// STRUCTURE
//  - Package alu_v_pkg holds:
//    - localparams for all 16 opcode encodings
//    - a typedef for one lane element
//  - Sub-module alu_v_lane: combinational single-lane datapath (DATA_WIDTH, selector, a, b -> y).
//  - alu_v instantiates alu_v_lane LANES times via generate, then one output register with sync reset.
// TESTING
//  - Reset: rst=1 one edge -> out=0 in every lane. Then deassert and resume.
//  - ADD 4'b0100:
//    - A={05,00,05,FF,05,02,04,01}, B={02,08,08,0F,06,04,05,01} (lane7..0)
//    - -> out={07,08,0D,0E,0B,06,09,02} one cycle later.
//  - SUB 4'b1101:
//    - A={05,05,05,FF,04,1F,0E,01}, B={08,08,08,0F,06,0E,02,01}
//    - -> out={FD,FD,FD,F0,FE,11,0C,00}.
//  - MUL 4'b0101:
//    - A={05,02,02,00,04,01,0E,01}, B={01,03,02,0F,00,0E,02,01}
//    - -> out={05,06,04,00,00,0E,1C,01}.
//  - Shifts/logic:
//    - A lanes=0x81, B lanes=0x01: SLL -> 0x02, SRL -> 0x40, SRA -> 0xC0, NOT -> 0x7E, EQ -> 0x00.
//    - Reserved 4'b1111 -> 0x00.
//  - Back-to-back: change selector ADD->SUB->MUL on consecutive edges.
//    - Each result appears exactly one cycle after its inputs.
//    - rst asserted mid-stream clears out on that edge.

Source files
------------

// File: rtl/alu_v_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_v_pkg
//  Brief    : Opcode encodings and lane element type for the vector ALU.
//  Revision : 1.0
// ============================================================================
package alu_v_pkg;

    localparam int c_DATA_WIDTH    = 8;
    localparam int c_SELECTOR_SIZE = 4;

    typedef logic [c_DATA_WIDTH-1:0] lane_t;

    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_AND   = 4'b0000;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_OR    = 4'b0001;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_XOR   = 4'b0010;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_NOT   = 4'b0011;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_ADD   = 4'b0100;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_MUL   = 4'b0101;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_SLL   = 4'b0110;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_SRL   = 4'b0111;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_SRA   = 4'b1000;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_MIN   = 4'b1001;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_MAX   = 4'b1010;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_PASSA = 4'b1011;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_PASSB = 4'b1100;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_SUB   = 4'b1101;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_EQ    = 4'b1110;
    localparam logic [c_SELECTOR_SIZE-1:0] c_OP_RSVD  = 4'b1111;

endpackage : alu_v_pkg
`default_nettype wire

// File: rtl/alu_v_lane.sv
`default_nettype none
// ============================================================================
//  Module   : alu_v_lane
//  Brief    : Combinational single-lane datapath of the vector ALU.
//  Revision : 1.0
// ============================================================================
module alu_v_lane
    import alu_v_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SELECTOR_SIZE = 4
) (
    input  logic [SELECTOR_SIZE-1:0] selector,
    input  logic [DATA_WIDTH-1:0]    a,
    input  logic [DATA_WIDTH-1:0]    b,
    output logic [DATA_WIDTH-1:0]    y
);

    localparam int c_SH_W = $clog2(DATA_WIDTH);

    // Only the low log2(width) bits of B steer the shifter
    logic [c_SH_W-1:0] w_sh;
    assign w_sh = b[c_SH_W-1:0];

    always_comb begin
        y = '0;
        case (selector)
            c_OP_AND:   y = a & b;
            c_OP_OR:    y = a | b;
            c_OP_XOR:   y = a ^ b;
            c_OP_NOT:   y = ~a;
            c_OP_ADD:   y = a + b;
            c_OP_MUL:   y = a * b;
            c_OP_SLL:   y = a << w_sh;
            c_OP_SRL:   y = a >> w_sh;
            c_OP_SRA:   y = $unsigned($signed(a) >>> w_sh);
            c_OP_MIN:   y = (a < b) ? a : b;
            c_OP_MAX:   y = (a > b) ? a : b;
            c_OP_PASSA: y = a;
            c_OP_PASSB: y = b;
            c_OP_SUB:   y = a - b;
            c_OP_EQ:    y = (a == b) ? '1 : '0;
            default:    y = '0;
        endcase
    end

endmodule : alu_v_lane
`default_nettype wire

// File: rtl/alu_v.sv
`default_nettype none
// ============================================================================
//  Module   : alu_v
//  Brief    : Lane-parallel vector ALU with a single registered result.
//  Revision : 1.0
// ============================================================================
module alu_v
    import alu_v_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 8,
    parameter int SELECTOR_SIZE = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SELECTOR_SIZE-1:0]            selector,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    operand1,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    operand2,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    out
);

    logic [LANES-1:0][DATA_WIDTH-1:0] w_result;
    logic [LANES-1:0][DATA_WIDTH-1:0] r_out;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            alu_v_lane #(
                .DATA_WIDTH    (DATA_WIDTH),
                .SELECTOR_SIZE (SELECTOR_SIZE)
            ) u_lane (
                .selector (selector),
                .a        (operand1[gi]),
                .b        (operand2[gi]),
                .y        (w_result[gi])
            );
        end
    endgenerate

    // Reset takes priority over any operation presented on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_result;
        end
    end

    assign out = r_out;

endmodule : alu_v
`default_nettype wire

// File: tb/tb_alu_v.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_v
//  Brief    : Scoreboard bench for alu_v against an integer reference model.
//  Revision : 1.0
// ============================================================================
module tb_alu_v;

    localparam int c_DW = 8;
    localparam int c_LN = 8;
    localparam int c_SS = 4;

    typedef logic [c_LN-1:0][c_DW-1:0] vec_t;

    typedef struct {
        vec_t   exp;
        int     sel;
        bit     rst;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [c_SS-1:0]  selector = '0;
    vec_t             operand1 = '0;
    vec_t             operand2 = '0;
    vec_t             out;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    bit               done = 1'b0;

    alu_v #(
        .DATA_WIDTH    (c_DW),
        .LANES         (c_LN),
        .SELECTOR_SIZE (c_SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .operand1 (operand1),
        .operand2 (operand2),
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic int ref_lane(input int op, input int a, input int b);
        int s;
        int p;
        s = b % 8;
        p = 1 << s;
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return a ^ b;
            3:  return 255 - a;
            4:  return (a + b) % 256;
            5:  return (a * b) % 256;
            6:  return (a * p) % 256;
            7:  return a / p;
            8:  return (a >= 128) ? (a / p) + (256 - 256 / p) : a / p;
            9:  return (a < b) ? a : b;
            10: return (a > b) ? a : b;
            11: return a;
            12: return b;
            13: return (a - b + 256) % 256;
            14: return (a == b) ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic vec_t ref_vec(input bit r, input int op, input vec_t a, input vec_t b);
        vec_t v;
        for (int i = 0; i < c_LN; i++) begin
            v[i] = r ? 8'h00 : 8'(ref_lane(op, int'(a[i]), int'(b[i])));
        end
        return v;
    endfunction

    task automatic issue(input bit r, input int op, input vec_t a, input vec_t b);
        exp_t e;
        @(negedge clk);
        rst      = r;
        selector = c_SS'(op);
        operand1 = a;
        operand2 = b;
        e.exp = ref_vec(r, op, a, b);
        e.sel = op;
        e.rst = r;
        sb_q.push_back(e);
    endtask

    function automatic vec_t splat(input logic [c_DW-1:0] x);
        vec_t v;
        for (int i = 0; i < c_LN; i++) v[i] = x;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < c_LN; i++) v[i] = 8'($urandom);
        return v;
    endfunction

    // Monitor: each edge retires exactly one expected result
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (out !== e.exp) begin
                n_errors++;
                $display("FAIL out sel=%0d rst=%0d got=%h expected=%h",
                         e.sel, e.rst, out, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete in time");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        vec_t a;
        vec_t b;
        int   op;
        bit   r;

        // Reset wins over live operands
        issue(1'b1, 4, {8'h05,8'h00,8'h05,8'hFF,8'h05,8'h02,8'h04,8'h01},
                       {8'h02,8'h08,8'h08,8'h0F,8'h06,8'h04,8'h05,8'h01});
        issue(1'b1, 14, splat(8'h33), splat(8'h33));

        // Directed vectors, back-to-back ADD -> SUB -> MUL
        issue(1'b0, 4,  {8'h05,8'h00,8'h05,8'hFF,8'h05,8'h02,8'h04,8'h01},
                        {8'h02,8'h08,8'h08,8'h0F,8'h06,8'h04,8'h05,8'h01});
        issue(1'b0, 13, {8'h05,8'h05,8'h05,8'hFF,8'h04,8'h1F,8'h0E,8'h01},
                        {8'h08,8'h08,8'h08,8'h0F,8'h06,8'h0E,8'h02,8'h01});
        issue(1'b0, 5,  {8'h05,8'h02,8'h02,8'h00,8'h04,8'h01,8'h0E,8'h01},
                        {8'h01,8'h03,8'h02,8'h0F,8'h00,8'h0E,8'h02,8'h01});

        // Shifts, logic and reserved on 0x81 / 0x01
        issue(1'b0, 6,  splat(8'h81), splat(8'h01));
        issue(1'b0, 7,  splat(8'h81), splat(8'h01));
        issue(1'b0, 8,  splat(8'h81), splat(8'h01));
        issue(1'b0, 3,  splat(8'h81), splat(8'h01));
        issue(1'b0, 14, splat(8'h81), splat(8'h01));
        issue(1'b0, 15, splat(8'h81), splat(8'h01));
        issue(1'b0, 14, splat(8'h5A), splat(8'h5A));

        // Shift amount 0 and amounts using only low bits of B
        issue(1'b0, 6,  splat(8'hA5), splat(8'h08));
        issue(1'b0, 8,  splat(8'hA5), splat(8'hFF));

        // Reset mid-stream, then resume
        issue(1'b0, 4,  splat(8'h10), splat(8'h20));
        issue(1'b1, 4,  splat(8'h10), splat(8'h20));
        issue(1'b0, 13, splat(8'h10), splat(8'h20));

        // Exhaustive opcode sweep on random data
        for (int k = 0; k < 16; k++) begin
            issue(1'b0, k, rnd_vec(), rnd_vec());
        end

        // Random stream with occasional reset
        for (int k = 0; k < 400; k++) begin
            op = int'($urandom_range(0, 15));
            r  = ($urandom_range(0, 19) == 0);
            a  = rnd_vec();
            b  = rnd_vec();
            issue(r, op, a, b);
        end

        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_v
`default_nettype wire
